// File: rtl/ysyx_22040750_axi_mem_slave.sv
// AXI4 burst slave: serves one read or write burst at a time on a 64-bit, 1-cycle-latency memory.
// Optional per-beat wait states are enabled by defining YSYX_22040750_AXI_SLV_DELAY_EN (parameter DELAY).
module ysyx_22040750_axi_mem_slave
`ifdef YSYX_22040750_AXI_SLV_DELAY_EN
#(
   parameter int unsigned DELAY = 4
)
`endif
(
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [31:0] I_axi_araddr,
   input  logic [7:0]  I_axi_arlen,
   input  logic [2:0]  I_axi_arsize,
   input  logic [1:0]  I_axi_arburst,
   input  logic        I_axi_arvalid,
   output logic        O_axi_arready,
   output logic [63:0] O_axi_rdata,
   output logic        O_axi_rvalid,
   output logic        O_axi_rlast,
   input  logic        I_axi_rready,
   input  logic [31:0] I_axi_awaddr,
   input  logic [7:0]  I_axi_awlen,
   input  logic [2:0]  I_axi_awsize,
   input  logic [1:0]  I_axi_awburst,
   input  logic        I_axi_awvalid,
   output logic        O_axi_awready,
   input  logic [63:0] I_axi_wdata,
   input  logic [7:0]  I_axi_wstrb,
   input  logic        I_axi_wlast,
   input  logic        I_axi_wvalid,
   output logic        O_axi_wready,
   output logic        O_axi_bvalid,
   input  logic        I_axi_bready,
   output logic [31:0] O_mem_addr,
   output logic        O_mem_ren,
   output logic        O_mem_wen,
   output logic [63:0] O_mem_wdata,
   output logic [7:0]  O_mem_wstrb,
   input  logic [63:0] I_mem_rdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned LW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_DATA,
      S_WR_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   beat_q, beat_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            fresh_q, fresh_d;
   logic [AW-1:0]   addr_next;
   logic            last_beat;
   logic            wait_ok;
   logic            unused_ok;

   // Beat count is driven purely by the latched length, so wlast carries no information here.
   assign unused_ok = &{1'b0, I_axi_wlast};

   assign addr_next   = (burst_q == 2'b00) ? addr_q : addr_q + (AW'(1) << size_q);
   assign last_beat   = (beat_q == len_q);
   // Memory data arrives the cycle after ren; show it directly on that cycle, then hold the copy.
   assign O_axi_rdata = rdata_d;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      size_d        = size_q;
      burst_d       = burst_q;
      beat_d        = beat_q;
      fresh_d       = 1'b0;
      rdata_d       = fresh_q ? I_mem_rdata : rdata_q;
      O_axi_arready = 1'b0;
      O_axi_awready = 1'b0;
      O_axi_rvalid  = 1'b0;
      O_axi_rlast   = 1'b0;
      O_axi_wready  = 1'b0;
      O_axi_bvalid  = 1'b0;
      O_mem_addr    = '0;
      O_mem_ren     = 1'b0;
      O_mem_wen     = 1'b0;
      O_mem_wdata   = '0;
      O_mem_wstrb   = '0;
      unique case (state_q)
         S_IDLE: begin
            O_axi_awready = 1'b1;
            O_axi_arready = ~I_axi_awvalid;
            if (I_axi_awvalid) begin
               addr_d  = I_axi_awaddr;
               len_d   = I_axi_awlen;
               size_d  = I_axi_awsize;
               burst_d = I_axi_awburst;
               beat_d  = '0;
               state_d = S_WR_DATA;
            end else if (I_axi_arvalid) begin
               addr_d  = I_axi_araddr;
               len_d   = I_axi_arlen;
               size_d  = I_axi_arsize;
               burst_d = I_axi_arburst;
               beat_d  = '0;
               state_d = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (wait_ok) begin
               O_mem_ren  = 1'b1;
               O_mem_addr = addr_q;
               fresh_d    = 1'b1;
               state_d    = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            O_axi_rvalid = 1'b1;
            O_axi_rlast  = last_beat;
            if (I_axi_rready) begin
               if (last_beat) begin
                  state_d = S_IDLE;
               end else begin
                  beat_d  = beat_q + LW'(1);
                  addr_d  = addr_next;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_WR_DATA: begin
            O_axi_wready = wait_ok;
            O_mem_addr   = addr_q;
            if (wait_ok && I_axi_wvalid) begin
               O_mem_wen   = 1'b1;
               O_mem_wdata = I_axi_wdata;
               O_mem_wstrb = I_axi_wstrb;
               if (last_beat) begin
                  state_d = S_WR_RESP;
               end else begin
                  beat_d = beat_q + LW'(1);
                  addr_d = addr_next;
               end
            end
         end
         S_WR_RESP: begin
            O_axi_bvalid = 1'b1;
            if (I_axi_bready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         rdata_q <= '0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         rdata_q <= rdata_d;
         fresh_q <= fresh_d;
      end
   end

`ifdef YSYX_22040750_AXI_SLV_DELAY_EN
   logic [7:0] wait_q, wait_d;

   assign wait_ok = (wait_q == 8'd0);

   // Reload on every entry to RD_REQ, on entry to WR_DATA, and after each accepted write beat.
   always_comb begin
      wait_d = wait_ok ? wait_q : wait_q - 8'd1;
      if ((state_d == S_RD_REQ && state_q != S_RD_REQ) ||
          (state_d == S_WR_DATA && (state_q != S_WR_DATA || O_mem_wen))) begin
         wait_d = 8'(DELAY);
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign wait_ok = 1'b1;
`endif

endmodule

// File: tb/tb_ysyx_22040750_axi_mem_slave.sv
// Randomized self-checking bench for ysyx_22040750_axi_mem_slave against a byte-level memory model.
module tb_ysyx_22040750_axi_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [63:0] rdata;
   logic        rvalid, rlast, rready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic        bvalid, bready;
   logic [31:0] mem_addr;
   logic        mem_ren, mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic [63:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ysyx_22040750_axi_mem_slave dut (
      .I_clk(clk), .I_rst(rst),
      .I_axi_araddr(araddr), .I_axi_arlen(arlen), .I_axi_arsize(arsize), .I_axi_arburst(arburst),
      .I_axi_arvalid(arvalid), .O_axi_arready(arready),
      .O_axi_rdata(rdata), .O_axi_rvalid(rvalid), .O_axi_rlast(rlast), .I_axi_rready(rready),
      .I_axi_awaddr(awaddr), .I_axi_awlen(awlen), .I_axi_awsize(awsize), .I_axi_awburst(awburst),
      .I_axi_awvalid(awvalid), .O_axi_awready(awready),
      .I_axi_wdata(wdata), .I_axi_wstrb(wstrb), .I_axi_wlast(wlast), .I_axi_wvalid(wvalid),
      .O_axi_wready(wready), .O_axi_bvalid(bvalid), .I_axi_bready(bready),
      .O_mem_addr(mem_addr), .O_mem_ren(mem_ren), .O_mem_wen(mem_wen),
      .O_mem_wdata(mem_wdata), .O_mem_wstrb(mem_wstrb), .I_mem_rdata(mem_rdata)
   );

   // Backing memory (word indexed by addr[13:3]) plus a log of every access the DUT makes.
   logic [63:0] mem       [2048];
   logic [63:0] model_mem [2048];
   logic [31:0] ren_log [$];
   logic [31:0] wa_log [$];
   logic [7:0]  ws_log [$];
   logic [63:0] wd_log [$];
   logic [63:0] mem_w;

   always @(posedge clk) begin
      if (mem_ren) begin
         mem_rdata <= mem[mem_addr[13:3]];
         ren_log.push_back(mem_addr);
      end
      if (mem_wen) begin
         mem_w = mem[mem_addr[13:3]];
         for (int b = 0; b < 8; b++) if (mem_wstrb[b]) mem_w[b*8 +: 8] = mem_wdata[b*8 +: 8];
         mem[mem_addr[13:3]] <= mem_w;
         wa_log.push_back(mem_addr);
         ws_log.push_back(mem_wstrb);
         wd_log.push_back(mem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                             input logic [2:0] size, input logic [1:0] burst);
      if (burst == 2'b00) return a;
      return a + (32'(k) << size);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Entered and left at negedge+1; abort_at >= 0 pulses reset while that beat is presented.
   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit bp, input int abort_at,
                          output int wait_cyc, output int first_cyc, output int last_cyc);
      int k, cyc;
      bit stall;
      logic [63:0] sdata;
      logic slast;
      logic [31:0] ea;
      ren_log.delete();
      araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      #1;
      wait_cyc = 0;
      while (!arready && wait_cyc < 50) begin @(negedge clk); #1; wait_cyc++; end
      chk1("ar_accept", arready, 1'b1);
      @(negedge clk);
      arvalid = 1'b0;
      k = 0; cyc = 1; stall = 0; first_cyc = -1; last_cyc = -1;
      while (k <= int'(len) && cyc < 3000) begin
         rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stall) begin
            chk1("r_hold_valid", rvalid, 1'b1);
            chk("r_hold_data", rdata, sdata);
            chk1("r_hold_last", rlast, slast);
         end
         stall = 0;
         if (rvalid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (k == abort_at) begin
               rst = 1'b1;
               #1;
               chk1("rst_rvalid", rvalid, 1'b0);
               chk1("rst_rlast", rlast, 1'b0);
               chk("rst_rdata", rdata, 64'd0);
               chk1("rst_ren", mem_ren, 1'b0);
               @(negedge clk);
               rst = 1'b0; rready = 1'b0;
               #1;
               chk1("rst_rel_arready", arready, 1'b1);
               chk1("rst_rel_rvalid", rvalid, 1'b0);
               chk1("rst_rel_bvalid", bvalid, 1'b0);
               return;
            end
            if (rready) begin
               ea = beat_addr(a, k, size, burst);
               chk("r_data", rdata, model_mem[ea[13:3]]);
               chk1("r_last", rlast, (k == int'(len)));
               if (k == int'(len)) last_cyc = cyc;
               k++;
            end else begin
               stall = 1; sdata = rdata; slast = rlast;
            end
         end
         @(negedge clk);
         cyc++;
      end
      rready = 1'b0;
      #1;
      chk("r_beats", 64'(k), 64'(int'(len) + 1));
      chk1("r_idle_rvalid", rvalid, 1'b0);
      chk1("r_idle_arready", arready, ~awvalid);
      chk("r_ren_count", 64'(ren_log.size()), 64'(int'(len) + 1));
      for (int i = 0; i < ren_log.size() && i <= int'(len); i++) begin
         ea = beat_addr(a, i, size, burst);
         chk("r_ren_addr", 64'(ren_log[i]), 64'(ea));
      end
   endtask

   // Entered and left at negedge+1; updates the model memory with the expected byte writes.
   task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit seq_data, input bit rand_strb,
                           input logic [7:0] strb, input bit early_last);
      logic [31:0] ea;
      logic [63:0] d, m;
      logic [7:0] s;
      int budget, hold;
      logic [31:0] exp_a [$];
      logic [7:0]  exp_s [$];
      logic [63:0] exp_d [$];
      wa_log.delete(); ws_log.delete(); wd_log.delete();
      awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      #1;
      budget = 0;
      while (!awready && budget < 50) begin @(negedge clk); #1; budget++; end
      chk1("aw_accept", awready, 1'b1);
      @(negedge clk);
      awvalid = 1'b0;
      #1;
      chk1("w_ready_t1", wready, 1'b1);
      for (int k = 0; k <= int'(len); k++) begin
         d = seq_data ? 64'(k + 1) : {$urandom, $urandom};
         s = rand_strb ? 8'($urandom) : strb;
         wvalid = 1'b1; wdata = d; wstrb = s;
         wlast = early_last ? (k == 0) : (k == int'(len));
         #1;
         budget = 0;
         while (!wready && budget < 50) begin @(negedge clk); #1; budget++; end
         chk1("w_ready", wready, 1'b1);
         chk1("w_mem_wen", mem_wen, 1'b1);
         ea = beat_addr(a, k, size, burst);
         exp_a.push_back(ea); exp_s.push_back(s); exp_d.push_back(d);
         m = model_mem[ea[13:3]];
         for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
         model_mem[ea[13:3]] = m;
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      #1;
      chk1("b_valid", bvalid, 1'b1);
      chk1("b_arready_lo", arready, 1'b0);
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(negedge clk); #1; chk1("b_hold", bvalid, 1'b1); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      #1;
      chk1("b_done", bvalid, 1'b0);
      chk1("b_arready", arready, 1'b1);
      chk("w_count", 64'(wa_log.size()), 64'(exp_a.size()));
      for (int i = 0; i < wa_log.size() && i < exp_a.size(); i++) begin
         chk("w_addr", 64'(wa_log[i]), 64'(exp_a[i]));
         chk("w_strb", 64'(ws_log[i]), 64'(exp_s[i]));
         chk("w_data", wd_log[i], exp_d[i]);
      end
   endtask

   initial begin
      int wc, fc, lc;
      logic [31:0] ra;
      logic [7:0] rl;
      logic [2:0] rs;
      logic [1:0] rb;

      for (int i = 0; i < 2048; i++) begin
         mem[i] = {$urandom, $urandom};
         model_mem[i] = mem[i];
      end
      rst = 1'b1;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk1("reset_rvalid_in_rst", rvalid, 1'b0);
      rst = 1'b0;
      #1;
      chk1("reset_arready", arready, 1'b1);
      chk1("reset_awready", awready, 1'b1);
      chk1("reset_rvalid", rvalid, 1'b0);
      chk1("reset_rlast", rlast, 1'b0);
      chk1("reset_wready", wready, 1'b0);
      chk1("reset_bvalid", bvalid, 1'b0);
      chk1("reset_ren", mem_ren, 1'b0);
      chk1("reset_wen", mem_wen, 1'b0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_mem_addr", 64'(mem_addr), 64'd0);

      // Single-beat read latency
      do_read(32'h8000_0000, 8'd0, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);
      chk("single_first_rvalid", 64'(fc), 64'd2);

      // 4-beat INCR refill, no back-pressure, then with random rready
      do_read(32'h8000_0020, 8'd3, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);
      chk("burst4_last_cycle", 64'(lc), 64'd8);
      do_read(32'h8000_0020, 8'd3, 3'd3, 2'b01, 1'b1, -1, wc, fc, lc);

      // 4-beat writeback with sequential data, then read it back
      do_write(32'h8000_1000, 8'd3, 3'd3, 2'b01, 1'b1, 1'b0, 8'hFF, 1'b0);
      do_read(32'h8000_1000, 8'd3, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);

      // AW and AR together: AW first, AR taken immediately after the B handshake
      araddr = 32'h8000_2000; arlen = 8'd1; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
      awvalid = 1'b1;
      #1;
      chk1("simul_arready_lo", arready, 1'b0);
      chk1("simul_awready", awready, 1'b1);
      do_write(32'h8000_2000, 8'd1, 3'd3, 2'b01, 1'b0, 1'b0, 8'hFF, 1'b0);
      do_read(32'h8000_2000, 8'd1, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);
      chk("simul_ar_wait", 64'(wc), 64'd0);

      // FIXED burst, partial strobe, early wlast
      do_write(32'h8000_3008, 8'd1, 3'd3, 2'b00, 1'b0, 1'b0, 8'h0F, 1'b1);
      do_read(32'h8000_3008, 8'd0, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);

      // Address wrap past 0xFFFFFFFF
      do_write(32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 1'b0, 1'b1, 8'h00, 1'b0);
      do_read(32'hFFFF_FFF0, 8'd3, 3'd3, 2'b01, 1'b1, -1, wc, fc, lc);

      // Reset during beat 2 of a 4-beat read, then a normal burst
      do_read(32'h8000_0040, 8'd3, 3'd3, 2'b01, 1'b0, 2, wc, fc, lc);
      do_read(32'h8000_0040, 8'd3, 3'd3, 2'b01, 1'b0, -1, wc, fc, lc);

      // Random mix of bursts
      for (int it = 0; it < 24; it++) begin
         ra = 32'h8000_0000 | ($urandom & 32'h0000_3FFF);
         rl = 8'($urandom_range(0, 15));
         rs = 3'($urandom_range(0, 3));
         rb = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1)
            do_write(ra, rl, rs, rb, 1'b0, 1'b1, 8'h00, 1'($urandom_range(0, 1)));
         else
            do_read(ra, rl, rs, rb, 1'($urandom_range(0, 1)), -1, wc, fc, lc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22040750_axi_mem_slave.md
# ysyx_22040750_axi_mem_slave

AXI4 burst responder that terminates the master-side AXI bus driven by the cache top: it accepts AR/R and AW/W/B transactions and converts them to beats on a single-port, 64-bit, 1-cycle-read-latency simulation/backing memory. It serves one transaction at a time: one read burst or one write burst. It is the memory end of the refill and writeback traffic generated by the I/D cache controllers and the crossbar.

## Interface
- DELAY, 4, extra wait cycles per beat (only with `YSYX_22040750_AXI_SLV_DELAY_EN`)
- I_clk  in  1  clock, all state on rising edge
- I_rst  in  1  asynchronous, active-high reset
- I_axi_araddr / I_axi_arlen / I_axi_arsize / I_axi_arburst  in  32/8/3/2  read address, beats-1, log2 bytes, burst type
- I_axi_arvalid  in  1; O_axi_arready  out  1
- O_axi_rdata  out  64; O_axi_rvalid  out  1; O_axi_rlast  out  1; I_axi_rready  in  1
- I_axi_awaddr / I_axi_awlen / I_axi_awsize / I_axi_awburst  in  32/8/3/2  write address group
- I_axi_awvalid  in  1; O_axi_awready  out  1
- I_axi_wdata  in  64; I_axi_wstrb  in  8; I_axi_wlast  in  1; I_axi_wvalid  in  1; O_axi_wready  out  1
- O_axi_bvalid  out  1; I_axi_bready  in  1
- O_mem_addr  out  32  beat byte address
- O_mem_ren  out  1  read strobe; data returned on I_mem_rdata next cycle
- O_mem_wen  out  1; O_mem_wdata  out  64; O_mem_wstrb  out  8  write beat, committed on this edge
- I_mem_rdata  in  64

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE: O_axi_awready=1. O_axi_arready = ~I_axi_awvalid. If AW and AR are valid in the same cycle, AW wins and AR waits.
- AW handshake latches awaddr/awlen/awsize/awburst, clears the beat counter, and moves to WR_DATA.
- AR handshake latches the AR group and moves to RD_REQ.
- RD_REQ: O_mem_ren=1, O_mem_addr=current address → RD_DATA.
- RD_DATA: I_mem_rdata is captured into the O_axi_rdata register on entry. O_axi_rvalid=1 and is held stable until I_axi_rready. O_axi_rlast=1 when beat counter == latched arlen.
- On the R handshake: if it was the last beat → IDLE, otherwise counter+1, address advance, → RD_REQ.
- WR_DATA: O_axi_wready=1. On a W handshake, O_mem_wen=1 in the same cycle, with wdata/wstrb passed through and O_mem_addr = current address.
- After a W handshake, if beat counter == awlen → WR_RESP, otherwise counter+1 and address advance.
- The beat counter is authoritative and I_axi_wlast is ignored. An early or missing wlast does not change the beat count.
- WR_RESP: O_axi_bvalid=1 until I_axi_bready, then → IDLE.
- Address advance rules:
  - burst 2'b00 (FIXED): address held.
  - any other burst code: address += (1 << size), 32-bit wrap-around at 0xFFFFFFFF→0.
  - No alignment of the start address is performed; an unaligned start address is presented verbatim on the first beat.
- Beat count is len+1, range 1..256. The counter is 8 bits and never wraps within a burst.

## Timing
- Reset values:
  - state=IDLE, so O_axi_arready=1 and O_axi_awready=1.
  - O_axi_rvalid, O_axi_rlast, O_axi_wready, O_axi_bvalid, O_mem_ren, O_mem_wen = 0.
  - O_axi_rdata=0, O_mem_addr=0.
- Read latency: AR handshake at cycle t → ren at t+1 → rvalid at t+2. With rready tied high, each subsequent beat costs 2 cycles, so a 4-beat burst has its last beat at t+8.
- Write: AW handshake at t → wready at t+1. With wvalid high, one beat per cycle. bvalid appears the cycle after the last W handshake.
- No new AR/AW is accepted until the current transaction's final R or B handshake; the next handshake is possible one cycle after that.
- Reset asserted mid-burst: all outputs drop asynchronously to reset values, the partial burst is abandoned, and no B response is issued.
- Back-pressure: rdata/rlast are stable while rvalid=1 and rready=0, and no further mem read is issued.

## Configuration
- `YSYX_22040750_AXI_SLV_DELAY_EN` defined:
  - a wait counter loaded with DELAY precedes every RD_REQ, and every write beat in WR_DATA (wready held 0 for DELAY cycles after entry and after each beat).
  - models slow memory; DELAY=0 behaves as undefined-macro.
- Undefined: no counter logic and zero added latency; timing is exactly as above.

## Test plan
- Single read: araddr=0x80000000, arlen=0, arsize=3, rready=1 → one ren at 0x80000000, rvalid two cycles after AR handshake with rlast=1, rdata = memory word.
- 4-beat INCR refill: araddr=0x80000020, arlen=3, arsize=3 → ren addresses 0x20,0x28,0x30,0x38 (offsets); rlast only on the fourth beat. rready toggled 1/0 per cycle → data stable during stalls, no extra ren.
- 4-beat writeback: awaddr=0x80001000, awlen=3, wstrb=0xFF, wdata=1..4 → mem writes at 0x1000..0x1018, one bvalid held until bready, then arready=1.
- Simultaneous awvalid and arvalid in IDLE → AW accepted first and arready=0 that cycle. AR accepted the cycle after the B handshake.
- Partial strobe and FIXED burst: awburst=0, awlen=1, wstrb=0x0F → two writes to the same address with wstrb=0x0F. wlast asserted on beat 0 → ignored, second beat still accepted.
- Reset pulse during beat 2 of a 4-beat read → rvalid=0 immediately, arready=1 after release, and a new burst completes normally.
